// File: rtl/div_arbiter_pkg.sv
// Shared types for the divider arbiter: FSM state encoding, divider status flags, ID width helper.
package div_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic dbz;
    logic ovf;
  } div_flags_t;

  // Width needed to name one of n requesters; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// Round-robin picker, purely combinational: first valid at or after ptr, wrapping modulo N.
// Zero latency; any=0 when no input is valid.
module rr_pick
  import div_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = id_w(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] grant
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  logic           found;

  // The lower copy is masked below ptr; the upper copy supplies the wrap-around candidates.
  always_comb begin
    dbl    = {valid, valid};
    masked = '0;
    for (int i = 0; i < 2*N; i++) begin
      masked[i] = dbl[i] & ((i >= N) || (i >= int'(ptr)));
    end
  end

  always_comb begin
    any   = |valid;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < 2*N; i++) begin
      if (!found && masked[i]) begin
        found = 1'b1;
        grant = PW'(i % N);
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin front end for one shared sequential divider; one transaction in flight.
// Grant to resp_valid is 2 + divider latency; resp_* hold until resp_ready, no grant meanwhile.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 16,
  parameter  int FBITS = 0,
  localparam int IDW   = id_w(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [IDW-1:0]          resp_id,
  output logic [WIDTH-1:0]        resp_val,
  output logic                    resp_dbz,
  output logic                    resp_ovf,
  output logic                    div_start,
  output logic [WIDTH-1:0]        div_a,
  output logic [WIDTH-1:0]        div_b,
  input  logic                    div_busy,
  input  logic                    div_done,
  input  logic [WIDTH-1:0]        div_val,
  input  logic                    div_dbz,
  input  logic                    div_ovf
);

  // FBITS only configures the external divider; reject values it could never accept.
  if (NREQ < 2 || FBITS < 0 || FBITS >= WIDTH) begin : g_bad_params
    $error("div_arbiter: need NREQ >= 2 and 0 <= FBITS < WIDTH");
  end

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q,   ptr_d;
  logic [IDW-1:0]   id_q,    id_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] val_q,   val_d;
  div_flags_t       flags_q, flags_d;

  logic             pick_any;
  logic [IDW-1:0]   pick_idx;
  logic [WIDTH-1:0] pick_a;
  logic [WIDTH-1:0] pick_b;

  rr_pick #(
    .N  (NREQ),
    .PW (IDW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .any   (pick_any),
    .grant (pick_idx)
  );

  always_comb begin
    pick_a = '0;
    pick_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IDW'(i)) begin
        pick_a = req_a[i*WIDTH +: WIDTH];
        pick_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      val_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      val_q   <= val_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any)   state_d = ISSUE;
      ISSUE:   if (!div_busy)  state_d = WAIT;
      WAIT:    if (div_done)   state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Operands are captured at grant and held through WAIT so the divider may sample them late.
  always_comb begin
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    val_d   = val_q;
    flags_d = flags_q;
    if (state_q == IDLE && pick_any) begin
      ptr_d = (pick_idx == IDW'(NREQ-1)) ? '0 : pick_idx + 1'b1;
      id_d  = pick_idx;
      a_d   = pick_a;
      b_d   = pick_b;
    end
    if (state_q == WAIT && div_done) begin
      val_d       = div_val;
      flags_d.dbz = div_dbz;
      flags_d.ovf = div_ovf;
    end
  end

  always_comb begin
    req_ready  = '0;
    div_start  = 1'b0;
    resp_valid = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = pick_any && (pick_idx == IDW'(i));
          end
        end
        ISSUE:   div_start  = !div_busy;
        RESP:    resp_valid = 1'b1;
        default: ;
      endcase
    end
  end

  assign div_a    = a_q;
  assign div_b    = b_q;
  assign resp_id  = id_q;
  assign resp_val = val_q;
  assign resp_dbz = flags_q.dbz;
  assign resp_ovf = flags_q.ovf;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural divider and a grant-time scoreboard.
module tb_div_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_val;
  logic              resp_dbz;
  logic              resp_ovf;
  logic              div_start;
  logic [W-1:0]      div_a;
  logic [W-1:0]      div_b;
  logic              div_busy;
  logic              div_done;
  logic [W-1:0]      div_val;
  logic              div_dbz;
  logic              div_ovf;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   val;
    logic           dbz;
    logic           ovf;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_start = 0;
  int   lat = 3;
  int   cyc = 0;
  int   g, g_cyc, r_cyc, hs_cyc, stale;
  int   mon_g;
  exp_t mon_e;
  logic force_busy = 1'b0;
  logic run = 1'b0;

  div_arbiter #(.NREQ(NREQ), .WIDTH(W), .FBITS(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_val   (resp_val),
    .resp_dbz   (resp_dbz),
    .resp_ovf   (resp_ovf),
    .div_start  (div_start),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .div_val    (div_val),
    .div_dbz    (div_dbz),
    .div_ovf    (div_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign div_busy = force_busy | run;

  // Reference signed division with saturating error results.
  function automatic exp_t ref_div(input logic [IDW-1:0] id, input logic signed [W-1:0] a,
                                   input logic signed [W-1:0] b);
    exp_t e;
    e.id  = id;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (b == '0) begin
      e.dbz = 1'b1;
      e.val = a[W-1] ? 16'h8000 : 16'h7fff;
    end else if (a == 16'sh8000 && b == -16'sd1) begin
      e.ovf = 1'b1;
      e.val = 16'h7fff;
    end else begin
      e.val = a / b;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural divider: done pulses lat cycles after the cycle start was seen high.
  initial begin : divider_model
    logic         st;
    logic [W-1:0] la, lb;
    int           rem;
    exp_t         r;
    div_done = 1'b0; div_val = '0; div_dbz = 1'b0; div_ovf = 1'b0;
    la = '0; lb = '0; rem = 0;
    forever begin
      @(negedge clk);
      st = div_start;
      @(posedge clk);
      #2;
      div_done = 1'b0;
      if (reset) begin
        run = 1'b0;
      end else begin
        if (st) begin
          run = 1'b1; rem = lat - 1; la = div_a; lb = div_b;
        end else if (run && rem > 0) begin
          rem--;
        end
        if (run && rem == 0) begin
          r = ref_div('0, la, lb);
          div_val = r.val; div_dbz = r.dbz; div_ovf = r.ovf;
          div_done = 1'b1;
          run = 1'b0;
        end
      end
    end
  end

  // Monitor: push expectation at each grant, compare at each response handshake.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (div_start) n_start++;
      if (!reset && req_ready != '0) begin
        check("req_ready_onehot", 64'($onehot(req_ready)), 64'(1));
        mon_g = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) mon_g = i;
        sb.push_back(ref_div(IDW'(mon_g), req_a[mon_g*W +: W], req_b[mon_g*W +: W]));
      end
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'(sb.size()), 64'(1));
        end else begin
          mon_e = sb.pop_front();
          check("sb_resp_id",  64'(resp_id),  64'(mon_e.id));
          check("sb_resp_val", 64'(resp_val), 64'(mon_e.val));
          check("sb_resp_dbz", 64'(resp_dbz), 64'(mon_e.dbz));
          check("sb_resp_ovf", 64'(resp_ovf), 64'(mon_e.ovf));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
    req_valid[i]    = 1'b1;
  endtask

  task automatic wait_grant(output int gi, input int budget);
    bit got = 1'b0;
    gi = -1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        got = 1'b1;
        for (int j = 0; j < NREQ; j++) if (req_ready[j]) gi = j;
      end
    end
    g_cyc = cyc;
    check("grant_seen", 64'(got), 64'(1));
  endtask

  task automatic wait_resp(input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
    end
    r_cyc = cyc;
    check("resp_seen", 64'(got), 64'(1));
  endtask

  initial begin : stimulus
    int order [5] = '{0, 1, 2, 3, 0};
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("reset_outputs", 64'({req_ready, resp_valid, resp_id, resp_val, resp_dbz, resp_ovf,
                                div_start, div_a, div_b}), 64'(0));
    tick();
    reset = 1'b0;

    // 1: single request, latency and one start pulse
    n_start = 0;
    set_req(0, 100, 7);
    wait_grant(g, 10);
    check("t1_grant", 64'(g), 64'(0));
    tick();
    req_valid[0] = 1'b0;
    wait_resp(30);
    check("t1_val",     64'(resp_val), 64'(16'd14));
    check("t1_dbz",     64'(resp_dbz), 64'(0));
    check("t1_latency", 64'(r_cyc - g_cyc), 64'(2 + lat));
    check("t1_starts",  64'(n_start), 64'(1));

    // 2: everyone requesting from reset, round-robin order
    tick();
    reset = 1'b1; tick(); tick(); reset = 1'b0; sb.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, 1000*(i+1) + 7, i + 2);
    for (int t = 0; t < 5; t++) begin
      wait_grant(g, 40);
      check("t2_grant", 64'(g), 64'(order[t]));
      tick();
      if (t < 4) set_req(g, -(t+1)*911, 13);
      else req_valid = '0;
      wait_resp(40);
      check("t2_resp_id", 64'(resp_id), 64'(order[t]));
    end

    // 3: divide by zero, then a normal request
    tick();
    set_req(2, 1234, 0);
    wait_grant(g, 20);
    check("t3_grant", 64'(g), 64'(2));
    tick();
    req_valid[2] = 1'b0;
    wait_resp(30);
    check("t3_dbz", 64'(resp_dbz), 64'(1));
    check("t3_id",  64'(resp_id),  64'(2));
    tick();
    set_req(3, -81, 9);
    wait_grant(g, 20);
    check("t3_next_grant", 64'(g), 64'(3));
    tick();
    req_valid[3] = 1'b0;
    wait_resp(30);
    check("t3_next_val", 64'(resp_val), 64'(16'hfff7));
    check("t3_next_dbz", 64'(resp_dbz), 64'(0));

    // 4: response backpressure with another requester waiting
    tick();
    resp_ready = 1'b0;
    set_req(1, 500, 10);
    wait_grant(g, 20);
    check("t4_grant", 64'(g), 64'(1));
    tick();
    req_valid[1] = 1'b0;
    set_req(0, 9, 3);
    wait_resp(30);
    repeat (5) begin
      check("t4_resp_hold", 64'({resp_valid, resp_id, resp_val, resp_dbz, resp_ovf}),
            64'({1'b1, 2'd1, 16'd50, 1'b0, 1'b0}));
      check("t4_no_ready", 64'(req_ready), 64'(0));
      @(negedge clk);
    end
    tick();
    resp_ready = 1'b1;
    @(negedge clk);
    hs_cyc = cyc;
    check("t4_no_bypass", 64'(req_ready), 64'(0));
    wait_grant(g, 10);
    check("t4_after_grant", 64'(g), 64'(0));
    check("t4_grant_gap", 64'(g_cyc - hs_cyc), 64'(1));
    tick();
    req_valid[0] = 1'b0;
    wait_resp(30);

    // 5: reset while waiting on the divider
    tick();
    lat = 6;
    set_req(1, 700, 7);
    wait_grant(g, 20);
    check("t5_grant", 64'(g), 64'(1));
    tick();
    req_valid[1] = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("t5_reset_outputs", 64'({req_ready, resp_valid, resp_id, resp_val, resp_dbz, resp_ovf,
                                   div_start, div_a, div_b}), 64'(0));
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid) stale++;
    end
    check("t5_no_stale_resp", 64'(stale), 64'(0));
    lat = 3;
    tick();
    set_req(1, -50, 5);
    set_req(3, 77, 7);
    wait_grant(g, 20);
    check("t5_ptr_reset_grant", 64'(g), 64'(1));
    tick();
    req_valid[1] = 1'b0;
    wait_resp(30);
    check("t5_val", 64'(resp_val), 64'(16'hfff6));
    check("t5_id",  64'(resp_id),  64'(1));
    wait_grant(g, 20);
    check("t5_second_grant", 64'(g), 64'(3));
    tick();
    req_valid[3] = 1'b0;
    wait_resp(30);

    // 6: divider busy while the arbiter sits in ISSUE
    tick();
    force_busy = 1'b1;
    n_start = 0;
    set_req(2, -300, -7);
    wait_grant(g, 20);
    check("t6_grant", 64'(g), 64'(2));
    tick();
    req_valid[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_start_held", 64'(div_start), 64'(0));
      check("t6_div_a", 64'(div_a), 64'(16'hfed4));
      tick();
    end
    force_busy = 1'b0;
    @(negedge clk);
    check("t6_start_now", 64'(div_start), 64'(1));
    wait_resp(30);
    check("t6_starts", 64'(n_start), 64'(1));
    check("t6_val",    64'(resp_val), 64'(16'd42));

    // overflow flag passes through
    tick();
    set_req(0, -32768, -1);
    wait_grant(g, 20);
    check("ovf_grant", 64'(g), 64'(0));
    tick();
    req_valid[0] = 1'b0;
    wait_resp(30);
    check("ovf_flag", 64'(resp_ovf), 64'(1));

    repeat (3) tick();
    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
